// File: rtl/reg_dump_tx.sv
// Post-halt register dump: HDR, 4 bytes per register MSB first, then an XOR checksum byte, on valid/ready.
// The header is offered one cycle after the halted rise. Each register adds one LOAD bubble, and every tx_ready=0 cycle stalls in place.
module reg_dump_tx #(
    parameter int          NUM_REGS = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        halted,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state;
    state_t      nxt;
    logic        halted_q;
    logic [4:0]  idx;
    logic [31:0] shift;
    logic [7:0]  csum;
    logic [1:0]  cnt;
    logic        start;

    assign start      = halted & ~halted_q;
    assign rf_rd_addr = idx;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) nxt = S_HDR;
            end
            S_HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) nxt = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                nxt  = S_SEND;
            end
            S_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = shift[31:24];
                if (tx_ready && cnt == 2'd3) begin
                    nxt = (idx == LAST_IDX) ? S_CSUM : S_LOAD;
                end
            end
            S_CSUM: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum;
                tx_last  = 1'b1;
                if (tx_ready) nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!halted) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // The word is captured only in LOAD, so register-file writes while SEND is stalled cannot reach the bytes in flight.
    always_ff @(posedge clk1) begin
        if (rst) begin
            halted_q <= 1'b0;
            idx      <= 5'd0;
            shift    <= 32'd0;
            csum     <= 8'd0;
            cnt      <= 2'd0;
        end else begin
            halted_q <= halted;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx  <= 5'd0;
                        csum <= 8'd0;
                    end
                end
                S_LOAD: begin
                    shift <= rf_rd_data;
                    cnt   <= 2'd0;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        shift <= shift << 8;
                        csum  <= csum ^ shift[31:24];
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3 && idx != LAST_IDX) idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: a 6-register and a 32-register instance, each checked against a byte-list frame model.
module tb_reg_dump_tx;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        halted6, halted32;
    logic [4:0]  addr6, addr32;
    logic [31:0] data6, data32;
    logic        valid6, valid32, ready6, ready32, last6, last32;
    logic        busy6, busy32, done6, done32;
    logic [7:0]  txd6, txd32;

    logic [31:0] rf6  [32];
    logic [31:0] rf32 [32];

    int total = 0;
    int bad   = 0;
    int wr_at = -1;
    int drop_at = -1;
    int stop_at = 0;
    int max_addr;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    bit         gl[$];

    always #5 clk1 = ~clk1;

    assign data6  = rf6[addr6];
    assign data32 = rf32[addr32];

    reg_dump_tx #(.NUM_REGS(6)) dut6 (
        .clk1(clk1), .rst(rst), .halted(halted6), .rf_rd_addr(addr6), .rf_rd_data(data6),
        .tx_valid(valid6), .tx_ready(ready6), .tx_data(txd6), .tx_last(last6),
        .busy(busy6), .done(done6)
    );

    reg_dump_tx #(.NUM_REGS(32)) dut32 (
        .clk1(clk1), .rst(rst), .halted(halted32), .rf_rd_addr(addr32), .rf_rd_data(data32),
        .tx_valid(valid32), .tx_ready(ready32), .tx_data(txd32), .tx_last(last32),
        .busy(busy32), .done(done32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Reference frame built straight from the register contents.
    task automatic build_exp(input bit sel);
        int n;
        logic [7:0]  cs;
        logic [31:0] w;
        logic [7:0]  b;
        n = sel ? 32 : 6;
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < n; k++) begin
            w = sel ? rf32[k] : rf6[k];
            for (int j = 3; j >= 0; j--) begin
                b = w[8*j +: 8];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic check_reset(input bit sel);
        chk("rst_valid", sel ? valid32 : valid6, 0);
        chk("rst_data",  sel ? txd32 : txd6, 0);
        chk("rst_last",  sel ? last32 : last6, 0);
        chk("rst_busy",  sel ? busy32 : busy6, 0);
        chk("rst_done",  sel ? done32 : done6, 0);
        chk("rst_addr",  sel ? addr32 : addr6, 0);
    endtask

    task automatic run_frame(input bit sel, input bit rnd, output int span, output int stalls);
        int first_v, done_c;
        bit v, l, d, r, pv_stall;
        logic [7:0] dt, pdata;
        logic [4:0] a;
        got.delete();
        gl.delete();
        first_v = -1;
        done_c = -1;
        stalls = 0;
        pv_stall = 0;
        pdata = 8'h00;
        max_addr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk1);
            v  = sel ? valid32 : valid6;
            l  = sel ? last32 : last6;
            d  = sel ? done32 : done6;
            dt = sel ? txd32 : txd6;
            a  = sel ? addr32 : addr6;
            if (v && first_v < 0) first_v = cyc;
            if (pv_stall) begin
                chk("stall_valid", v, 1);
                chk("stall_data", dt, pdata);
            end
            if (d) begin
                done_c = cyc;
                break;
            end
            if (int'(a) > max_addr) max_addr = int'(a);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel) ready32 = r; else ready6 = r;
            if (v && r) begin
                got.push_back(dt);
                gl.push_back(l);
            end
            if (v && !r) stalls++;
            pv_stall = v && !r;
            pdata = dt;
            if (wr_at >= 0 && got.size() == wr_at) begin
                rf6[3] = 32'hFFFF_FFFF;
                wr_at = -1;
            end
            if (drop_at >= 0 && got.size() == drop_at) begin
                if (sel) halted32 = 1'b0; else halted6 = 1'b0;
                drop_at = -1;
            end
            if (stop_at > 0 && got.size() == stop_at) break;
        end
        if (stop_at == 0) chk("done_seen", done_c >= 0, 1);
        span = done_c - first_v;
    endtask

    task automatic compare_frame(input string tg);
        chk({tg, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tg, i), got[i], exp_q[i]);
            chk($sformatf("%s_last%0d", tg, i), gl[i], (i == exp_q.size() - 1));
        end
    endtask

    initial begin
        int span, st;
        bit any_v, all_d;
        rst = 1'b1;
        halted6 = 1'b0;
        halted32 = 1'b0;
        ready6 = 1'b0;
        ready32 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rf6[k]  = 32'd0;
            rf32[k] = 32'(k);
        end
        repeat (3) @(negedge clk1);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk1);

        // Nominal frame, sink always ready.
        rf6[0] = 32'd0;  rf6[1] = 32'd10; rf6[2] = 32'd20;
        rf6[3] = 32'd25; rf6[4] = 32'd30; rf6[5] = 32'd55;
        build_exp(0);
        halted6 = 1'b1;
        run_frame(0, 0, span, st);
        compare_frame("nom");
        chk("nom_span", span, 32);
        chk("nom_maxaddr", max_addr, 5);

        // Staying halted must not retrigger.
        any_v = 0;
        all_d = 1;
        repeat (20) begin
            @(negedge clk1);
            any_v |= valid6;
            all_d &= done6;
        end
        chk("hold_no_tx", any_v, 0);
        chk("hold_done", all_d, 1);
        halted6 = 1'b0;
        @(negedge clk1);
        chk("rearm_done_low", done6, 0);
        chk("rearm_busy_low", busy6, 0);

        // Second frame under backpressure, R3 overwritten while its bytes are in flight.
        halted6 = 1'b1;
        wr_at = 14;
        run_frame(0, 1, span, st);
        compare_frame("bp");
        chk("bp_span", span, 32 + st);
        rf6[3] = 32'd25;

        // Random contents; halted falls mid-frame and DONE exits straight away.
        halted6 = 1'b0;
        @(negedge clk1);
        for (int k = 0; k < 6; k++) rf6[k] = $urandom;
        build_exp(0);
        halted6 = 1'b1;
        drop_at = 7;
        run_frame(0, 1, span, st);
        compare_frame("rnd");
        chk("rnd_span", span, 32 + st);
        @(negedge clk1);
        chk("drop_done_pulse", done6, 0);

        // Reset after the 10th byte, then a fresh frame with halted still high.
        for (int k = 0; k < 6; k++) rf6[k] = $urandom;
        build_exp(0);
        halted6 = 1'b1;
        stop_at = 10;
        run_frame(0, 1, span, st);
        stop_at = 0;
        @(negedge clk1);
        ready6 = 1'b0;
        rst = 1'b1;
        @(negedge clk1);
        check_reset(0);
        rst = 1'b0;
        run_frame(0, 1, span, st);
        compare_frame("postrst");
        chk("postrst_span", span, 32 + st);
        halted6 = 1'b0;

        // Full 32-register file, Reg[k] = k.
        build_exp(1);
        halted32 = 1'b1;
        run_frame(1, 0, span, st);
        compare_frame("full");
        chk("full_len130", got.size(), 130);
        if (got.size() > 0) chk("full_csum", got[got.size() - 1], 8'h00);
        chk("full_span", span, 162);
        chk("full_maxaddr", max_addr, 31);
        halted32 = 1'b0;
        repeat (2) @(negedge clk1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Post-halt register-file dump transmitter for the MIPS32 pipeline. When the core's `HALTED` flag rises, the block walks the register file through a read port. It streams a framed, checksummed byte image of the registers out over a valid/ready byte interface. This makes the architectural result readable by a host or a bench without hierarchical access. It is the readback end of the program-load/execute flow: the loader writes the program, the core executes it, and `reg_dump_tx` reads out the results.

## Interface
Parameters:
- `NUM_REGS`, default 32: number of registers dumped, R0..R(NUM_REGS-1); legal range 1..32.
- `HDR_BYTE`, default 8'hA5: frame start byte.

Ports:
- `clk1`, input, 1: single clock; all state changes on the rising edge. Same net as core phase-1 clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `halted`, input, 1: core `HALTED` flag.
- `rf_rd_addr`, output, 5: register-file read address.
- `rf_rd_data`, input, 32: register-file read data, combinational from `rf_rd_addr` in the same cycle.
- `tx_valid`, output, 1: `tx_data` holds a byte.
- `tx_ready`, input, 1: sink accepts the byte; a transfer occurs on a cycle where `tx_valid` and `tx_ready` are both 1.
- `tx_data`, output, 8: byte being offered.
- `tx_last`, output, 1: marks the final byte of the frame (the checksum byte).
- `busy`, output, 1: a frame is in progress.
- `done`, output, 1: a frame has completed; held until re-armed.

## Operation
- **Frame layout:**
  - `HDR_BYTE`;
  - then, for each register k = 0..NUM_REGS-1, 4 bytes MSB first;
  - then 1 checksum byte, the XOR of all 4·NUM_REGS data bytes (header excluded).
  - Frame length is 4·NUM_REGS+2 bytes.
- **Trigger:** `halted_q` is the registered copy of `halted` and resets to 0. A start occurs when `halted`=1 and `halted_q`=0 at a clock edge. A core that is already halted when reset releases is therefore dumped once.
- **States:** IDLE, HDR, LOAD, SEND, CSUM, DONE.
- **IDLE:**
  - Outputs are quiet.
  - On a start: go to HDR, set the register index to 0, clear the checksum.
- **HDR:**
  - `tx_valid`=1, `tx_data`=HDR_BYTE.
  - On transfer: go to LOAD.
- **LOAD:**
  - `tx_valid`=0 for this one cycle.
  - `rf_rd_addr` = index; `rf_rd_data` is latched into a 32-bit shift register at the end of the cycle.
  - Go to SEND with byte count 0.
- **SEND:**
  - `tx_valid`=1, `tx_data`=shift[31:24].
  - On transfer: shift left by 8, XOR the byte into the checksum, increment the byte count.
  - After the 4th byte: if index = NUM_REGS-1, go to CSUM; otherwise increment the index and go to LOAD.
- **CSUM:**
  - `tx_valid`=1, `tx_data`=checksum, `tx_last`=1.
  - On transfer: go to DONE.
- **DONE:**
  - `done`=1.
  - Leave for IDLE on the first cycle in which `halted`=0, which re-arms the trigger.
- **Output flags:** `busy`=1 in HDR, LOAD, SEND and CSUM. `tx_last`=1 only in CSUM.
- **Valid/data stability:** once `tx_valid` rises, `tx_valid` and `tx_data` stay constant until the transfer. No byte may be dropped or duplicated under any `tx_ready` pattern.
- **`halted` during a frame:** a fall of `halted` mid-frame does not abort the frame. The frame completes and DONE then exits to IDLE immediately. A new rising edge of `halted` during a frame is ignored.
- **Reset mid-frame:** `rst` aborts the frame with no further bytes sent and no `tx_last` asserted. The next frame starts from the header.
- **Reset values:** state=IDLE; `halted_q`=0; `tx_valid`=0, `tx_data`=0, `tx_last`=0, `busy`=0, `done`=0, `rf_rd_addr`=0; checksum=0; index=0.

## Timing
- **Start latency:** a start is detected at edge N. `tx_valid` (header) is high in the cycle following edge N.
- **Throughput with `tx_ready` held at 1:**
  - header 1 cycle;
  - 5 cycles per register (1 LOAD bubble + 4 bytes);
  - checksum 1 cycle.
  - Total is 5·NUM_REGS+2 cycles from the first `tx_valid` to DONE.
- `done` rises the cycle after the checksum transfer.
- **Backpressure:** each cycle with `tx_ready`=0 while `tx_valid`=1 adds exactly one cycle of stall. State, index, shift register and checksum all hold during a stall.
- **`rf_rd_addr` timing:**
  - `rf_rd_addr` must be valid by the LOAD cycle.
  - `rf_rd_data` is sampled only in LOAD, never while the frame stalls in SEND.
  - Register-file writes during SEND therefore do not corrupt the word in flight.
- **Index and address width:** the index is 5 bits. `rf_rd_addr` never exceeds NUM_REGS-1, and for NUM_REGS=32 the index does not wrap.

## Test plan
- **Nominal frame:** NUM_REGS=6; regs = 0, 10, 20, 25, 30, 55; `tx_ready`=1; raise `halted`.
  - Required response: 26 bytes in order A5, 00 00 00 00, 00 00 00 0A, 00 00 00 14, 00 00 00 19, 00 00 00 1E, 00 00 00 37, 2E.
  - `tx_last` is 1 only on the 2E byte.
  - `done` rises 32 cycles after the first `tx_valid`.
- **Backpressure:** same setup, with `tx_ready` driven by a pseudo-random pattern at 50% duty.
  - Required response: an identical byte sequence.
  - `tx_data` is stable whenever `tx_valid`=1 and `tx_ready`=0.
  - Total cycles = 32 + number of stall cycles.
- **Write during SEND:** overwrite R3 with 32'hFFFFFFFF while R3's bytes are being sent (SEND, index 3).
  - Required response: the old value 00 00 00 19 is still sent for R3.
- **Re-arm:**
  - Hold `halted`=1 after `done`: no second frame is sent.
  - Drop `halted`, then raise it again: a second frame, identical to the first, is sent.
- **Reset mid-frame:** assert `rst` for 1 cycle after the 10th byte.
  - Required response: all outputs are 0 the next cycle.
  - With `halted` still 1, a fresh full frame starting with A5 follows.
- **Full register file:** NUM_REGS=32 with Reg[k]=k.
  - Required response: 130 bytes; `rf_rd_addr` reaches 31 without wrapping.
  - Checksum = XOR of 0..31 = 8'h00.
